// File: rtl/fetch_if.sv
// fetch_if: hazard/redirect controls, instruction-memory link and IF/ID outputs of the fetch stage.
interface fetch_if;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] address;
   logic [31:0] instruction;
   logic [31:0] ifid_instruction;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic        fetch_misalign;
   logic        fetch_halted;
   modport master (
      output stall, flush, redirect, redirect_pc, instruction,
      input  address, ifid_instruction, ifid_pc, ifid_pc_plus4, ifid_valid,
             fetch_misalign, fetch_halted
   );
   modport slave (
      input  stall, flush, redirect, redirect_pc, instruction,
      output address, ifid_instruction, ifid_pc, ifid_pc_plus4, ifid_valid,
             fetch_misalign, fetch_halted
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline register and RUN/HALT fetch FSM.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 1024,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
   input logic     clk,
   input logic     rst_n,
   fetch_if.slave  fe_io
);
   typedef enum logic {RUN, HALT} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ins_q, ins_d, ipc_q, ipc_d, ip4_q, ip4_d;
   logic        valid_q, valid_d, mis_q, mis_d;
   logic [31:0] pc_plus4;
   logic        out_of_range;
   assign pc_plus4     = pc_q + 32'd4;
   assign out_of_range = ({1'b0, pc_q} + 33'd3) >= 33'(MEM_BYTES);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         ins_q   <= NOP_WORD;
         ipc_q   <= 32'd0;
         ip4_q   <= 32'd0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         ipc_q   <= ipc_d;
         ip4_q   <= ip4_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end
   // Bubbles only replace the word and valid bit; the PC fields keep their last values.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      ipc_d   = ipc_q;
      ip4_d   = ip4_q;
      valid_d = valid_q;
      mis_d   = 1'b0;
      if (fe_io.redirect) begin
         pc_d    = {fe_io.redirect_pc[31:2], 2'b00};
         mis_d   = |fe_io.redirect_pc[1:0];
         state_d = RUN;
         ins_d   = NOP_WORD;
         valid_d = 1'b0;
      end else if (state_q == HALT || out_of_range) begin
         state_d = HALT;
         ins_d   = NOP_WORD;
         valid_d = 1'b0;
      end else if (fe_io.flush) begin
         pc_d    = fe_io.stall ? pc_q : pc_plus4;
         ins_d   = NOP_WORD;
         valid_d = 1'b0;
      end else if (!fe_io.stall) begin
         pc_d    = pc_plus4;
         ins_d   = fe_io.instruction;
         ipc_d   = pc_q;
         ip4_d   = pc_plus4;
         valid_d = 1'b1;
      end
   end
   assign fe_io.address          = pc_q;
   assign fe_io.ifid_instruction = ins_q;
   assign fe_io.ifid_pc          = ipc_q;
   assign fe_io.ifid_pc_plus4    = ip4_q;
   assign fe_io.ifid_valid       = valid_q;
   assign fe_io.fetch_misalign   = mis_q;
   assign fe_io.fetch_halted     = (state_q == HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run against a rule-level fetch model.
module tb_fetch_stage;
   localparam int MB = 1024;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   fetch_if f();
   fetch_stage #(.RESET_PC(32'h0), .MEM_BYTES(MB), .NOP_WORD(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .fe_io(f)
   );
   always #5 clk = ~clk;
   logic [7:0] mem [MB];
   int checks = 0;
   int passed = 0;
   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (longint'(a) + 3 >= MB) return 32'hBAD0_BAD0;
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction
   always_comb f.instruction = word_at(f.address);
   logic [31:0] m_pc, m_ins, m_ipc, m_ip4;
   logic        m_valid, m_mis, m_halt;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_in(input logic s, input logic fl, input logic r, input logic [31:0] rp);
      f.stall = s; f.flush = fl; f.redirect = r; f.redirect_pc = rp;
   endtask
   task automatic test_reset();
      checks++; if (f.address !== 32'h0) $display("FAIL reset_address got %h exp %h", f.address, 32'h0); else passed++;
      checks++; if ({f.ifid_instruction, f.ifid_pc, f.ifid_pc_plus4} !== 96'h0) $display("FAIL reset_ifid got %h exp 0", {f.ifid_instruction, f.ifid_pc, f.ifid_pc_plus4}); else passed++;
      checks++; if ({f.ifid_valid, f.fetch_misalign, f.fetch_halted} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {f.ifid_valid, f.fetch_misalign, f.fetch_halted}); else passed++;
   endtask
   task automatic test_first_fetch();
      rst_n = 1'b1;
      repeat (3) step();
      checks++; if (f.ifid_pc !== 32'h8) $display("FAIL first_pc got %h exp %h", f.ifid_pc, 32'h8); else passed++;
      checks++; if (f.ifid_instruction !== 32'h0528_5024) $display("FAIL first_ins got %h exp %h", f.ifid_instruction, 32'h0528_5024); else passed++;
      checks++; if (f.ifid_pc_plus4 !== 32'hC) $display("FAIL first_pc4 got %h exp %h", f.ifid_pc_plus4, 32'hC); else passed++;
      checks++; if (f.ifid_valid !== 1'b1) $display("FAIL first_valid got %b exp 1", f.ifid_valid); else passed++;
   endtask
   task automatic test_stall();
      logic [31:0] w;
      step();
      w = word_at(32'hC);
      set_in(1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (f.address !== 32'h10) $display("FAIL stall_addr got %h exp %h", f.address, 32'h10); else passed++;
         checks++; if ({f.ifid_instruction, f.ifid_pc, f.ifid_pc_plus4, f.ifid_valid} !== {w, 32'hC, 32'h10, 1'b1})
            $display("FAIL stall_ifid got %h exp %h", {f.ifid_instruction, f.ifid_pc, f.ifid_pc_plus4, f.ifid_valid}, {w, 32'hC, 32'h10, 1'b1}); else passed++;
      end
      set_in(0, 0, 0, 0);
      step();
      checks++; if (f.address !== 32'h14) $display("FAIL stall_release got %h exp %h", f.address, 32'h14); else passed++;
   endtask
   task automatic test_redirect();
      set_in(1, 0, 1, 32'h58);
      step();
      checks++; if ({f.address, f.ifid_valid, f.fetch_misalign} !== {32'h58, 2'b00}) $display("FAIL redir_pc got %h exp %h", {f.address, f.ifid_valid, f.fetch_misalign}, {32'h58, 2'b00}); else passed++;
      set_in(0, 0, 0, 0);
      step();
      checks++; if ({f.ifid_pc, f.ifid_valid} !== {32'h58, 1'b1}) $display("FAIL redir_ifid got %h exp %h", {f.ifid_pc, f.ifid_valid}, {32'h58, 1'b1}); else passed++;
      set_in(0, 0, 1, 32'h66);
      step();
      checks++; if ({f.address, f.fetch_misalign} !== {32'h64, 1'b1}) $display("FAIL misalign_set got %h exp %h", {f.address, f.fetch_misalign}, {32'h64, 1'b1}); else passed++;
      set_in(0, 0, 0, 0);
      step();
      checks++; if ({f.ifid_pc, f.fetch_misalign} !== {32'h64, 1'b0}) $display("FAIL misalign_clr got %h exp %h", {f.ifid_pc, f.fetch_misalign}, {32'h64, 1'b0}); else passed++;
      set_in(0, 1, 0, 0);
      step();
      checks++; if ({f.address, f.ifid_instruction, f.ifid_valid} !== {32'h6C, 32'h0, 1'b0}) $display("FAIL flush got %h exp %h", {f.address, f.ifid_instruction, f.ifid_valid}, {32'h6C, 32'h0, 1'b0}); else passed++;
      set_in(0, 0, 0, 0);
   endtask
   task automatic test_halt();
      int n = 0;
      set_in(0, 0, 1, 32'h3F0);
      step();
      set_in(0, 0, 0, 0);
      while (f.fetch_halted !== 1'b1 && n < 20) begin
         checks++; if (f.address > 32'h3FC && f.ifid_valid === 1'b1 && f.ifid_pc >= 32'h3FD) $display("FAIL halt_illegal_valid got %h exp <3FD", f.ifid_pc); else passed++;
         step();
         n++;
      end
      checks++; if (n != 5) $display("FAIL halt_latency got %0d exp 5", n); else passed++;
      set_in(1, 0, 0, 0);
      repeat (2) step();
      checks++; if ({f.address, f.ifid_valid, f.fetch_halted} !== {32'h400, 2'b01}) $display("FAIL halt_hold got %h exp %h", {f.address, f.ifid_valid, f.fetch_halted}, {32'h400, 2'b01}); else passed++;
      set_in(0, 0, 1, 32'h4);
      step();
      checks++; if ({f.address, f.fetch_halted} !== {32'h4, 1'b0}) $display("FAIL halt_exit got %h exp %h", {f.address, f.fetch_halted}, {32'h4, 1'b0}); else passed++;
      set_in(0, 0, 0, 0);
      step();
      checks++; if ({f.ifid_pc, f.ifid_valid} !== {32'h4, 1'b1}) $display("FAIL halt_resume got %h exp %h", {f.ifid_pc, f.ifid_valid}, {32'h4, 1'b1}); else passed++;
      set_in(0, 0, 1, 32'h500);
      step();
      set_in(0, 0, 0, 0);
      checks++; if (f.fetch_halted !== 1'b0) $display("FAIL rehalt_run got %b exp 0", f.fetch_halted); else passed++;
      step();
      checks++; if ({f.address, f.ifid_valid, f.fetch_halted} !== {32'h500, 2'b01}) $display("FAIL rehalt got %h exp %h", {f.address, f.ifid_valid, f.fetch_halted}, {32'h500, 2'b01}); else passed++;
   endtask
   task automatic test_async_reset();
      set_in(0, 0, 1, 32'h20);
      step();
      set_in(0, 0, 0, 0);
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      test_reset();
      #1 rst_n = 1'b1;
      step();
      checks++; if ({f.ifid_pc, f.ifid_valid, f.address} !== {32'h0, 1'b1, 32'h4}) $display("FAIL async_first got %h exp %h", {f.ifid_pc, f.ifid_valid, f.address}, {32'h0, 1'b1, 32'h4}); else passed++;
   endtask
   task automatic model_edge(input logic s, input logic fl, input logic r, input logic [31:0] rp);
      logic [31:0] w = word_at(m_pc);
      m_mis = 1'b0;
      if (r) begin
         m_pc = rp & 32'hFFFF_FFFC; m_mis = (rp % 4) != 0; m_halt = 1'b0; m_ins = 0; m_valid = 0;
      end else if (m_halt || longint'(m_pc) + 3 >= MB) begin
         m_halt = 1'b1; m_ins = 0; m_valid = 0;
      end else begin
         if (fl) begin m_ins = 0; m_valid = 0; end
         else if (!s) begin m_ins = w; m_ipc = m_pc; m_ip4 = m_pc + 4; m_valid = 1; end
         if (!s) m_pc = m_pc + 4;
      end
   endtask
   task automatic test_random();
      logic s, fl, r;
      logic [31:0] rp;
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m_pc = 0; m_ins = 0; m_ipc = 0; m_ip4 = 0; m_valid = 0; m_mis = 0; m_halt = 0;
      for (int i = 0; i < 400; i++) begin
         s = ($urandom % 4) == 0;
         fl = ($urandom % 8) == 0;
         r = ($urandom % 10) == 0;
         rp = $urandom_range(0, 32'h420);
         set_in(s, fl, r, rp);
         model_edge(s, fl, r, rp);
         step();
         checks++;
         if ({f.address, f.ifid_instruction, f.ifid_pc, f.ifid_pc_plus4, f.ifid_valid, f.fetch_misalign, f.fetch_halted}
             !== {m_pc, m_ins, m_ipc, m_ip4, m_valid, m_mis, m_halt})
            $display("FAIL random_%0d got %h exp %h", i,
               {f.address, f.ifid_instruction, f.ifid_pc, f.ifid_pc_plus4, f.ifid_valid, f.fetch_misalign, f.fetch_halted},
               {m_pc, m_ins, m_ipc, m_ip4, m_valid, m_mis, m_halt});
         else passed++;
      end
      set_in(0, 0, 0, 0);
   endtask
   initial begin
      for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
      mem[8] = 8'h24; mem[9] = 8'h50; mem[10] = 8'h28; mem[11] = 8'h05;
      set_in(0, 0, 0, 0);
      #12;
      test_reset();
      test_first_fetch();
      test_stall();
      test_redirect();
      test_halt();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
